// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculation-core driver.
//   DATA_W           operand / result width
//   TIMER_W          width of the shared timeout counter
//   *_TIMEOUT_DEF    default timeout limits, in clock cycles
//   state_t          driver FSM state encoding
package calc_pkg;

  localparam int DATA_W           = 8;
  localparam int TIMER_W          = 10;
  localparam int ACK_TIMEOUT_DEF  = 4;
  localparam int DONE_TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: saturating cycle counter with a limit compare.
//   clk, reset  clock and asynchronous active-high reset
//   clear       synchronous clear to zero (wins over enable)
//   enable      count this cycle
//   limit       number of enabled cycles allowed
//   expired     high during the last allowed cycle (count == limit-1 or beyond)
module cycle_timer
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  localparam logic [TIMER_W-1:0] CNT_MAX  = '1;
  localparam logic [TIMER_W-1:0] CNT_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W:0]   WIDE_ONE = (TIMER_W+1)'(1);

  logic [TIMER_W-1:0] count;

  // Flag the final permitted cycle so the owner leaves on that very edge,
  // which makes the time spent waiting equal to limit cycles exactly.
  assign expired = ({1'b0, count} + WIDE_ONE) >= {1'b0, limit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/calc_driver.sv
// calc_driver: accepts operand pairs, launches the calculation core with a
// one-cycle Start pulse, waits for the Busy handshake (with timeouts) and
// returns the captured result through a valid/ready response port.
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/ready/a/b     operand request handshake
//   Start, InA, InB         launch pulse and operands to the core
//   Busy, Out               core busy flag and result
//   rsp_valid/ready         response handshake
//   rsp_data, rsp_err       captured result, timeout flag
//   op_count                completed transactions (wraps)
module calc_driver
  import calc_pkg::*;
#(
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              Start,
  output logic [DATA_W-1:0] InA,
  output logic [DATA_W-1:0] InB,
  input  logic              Busy,
  input  logic [DATA_W-1:0] Out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [7:0]        op_count
);

  localparam logic [TIMER_W-1:0] ACK_LIM  = TIMER_W'(ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0] DONE_LIM = TIMER_W'(DONE_TIMEOUT);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               cap_ok;
  logic               cap_err;
  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_expired;
  logic [TIMER_W-1:0] tmr_limit;

  assign req_ready = (state == IDLE) && !Busy;
  assign accept    = req_valid && req_ready;
  assign Start     = (state == LAUNCH);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    cap_ok     = 1'b0;
    cap_err    = 1'b0;
    unique case (state)
      IDLE:      if (accept) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_ACK;
      // A Busy seen on the last allowed cycle still counts as an ack.
      WAIT_ACK: begin
        if (Busy) begin
          state_next = WAIT_DONE;
        end else if (tmr_expired) begin
          state_next = RESP;
          cap_err    = 1'b1;
        end
      end
      // Completion wins over the timeout on the same cycle.
      WAIT_DONE: begin
        if (!Busy) begin
          state_next = RESP;
          cap_ok     = 1'b1;
        end else if (tmr_expired) begin
          state_next = RESP;
          cap_err    = 1'b1;
        end
      end
      RESP:      if (rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // One timer serves both waits; any state change restarts it.
  assign tmr_clear = (state_next != state);
  assign tmr_en    = (state == WAIT_ACK) || (state == WAIT_DONE);
  assign tmr_limit = (state == WAIT_ACK) ? ACK_LIM : DONE_LIM;

  cycle_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      InA      <= '0;
      InB      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_next;
      // Operands only load on acceptance, so they hold through the whole job.
      if (accept) begin
        InA <= req_a;
        InB <= req_b;
      end
      if (cap_ok) begin
        rsp_data <= Out;
        rsp_err  <= 1'b0;
      end else if (cap_err) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: directed and randomized checks of calc_driver against a
// transaction-level model of the core handshake and expected latencies.
module tb_calc_driver;

  localparam int ACK_T  = 4;
  localparam int DONE_T = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic       Start;
  logic [7:0] InA, InB;
  logic       Busy;
  logic [7:0] Out;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] op_count;

  int checks    = 0;
  int failures  = 0;
  int exp_cnt   = 0;
  int start_cnt = 0;
  int viol      = 0;
  logic [7:0] held_a, held_b;
  logic       have_held = 1'b0;

  always #5 clk = ~clk;

  calc_driver #(.ACK_TIMEOUT(ACK_T), .DONE_TIMEOUT(DONE_T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .Start(Start), .InA(InA), .InB(InB), .Busy(Busy), .Out(Out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  // Count Start pulses and watch that operands stay put while the core is busy.
  always @(negedge clk) begin
    if (reset) begin
      have_held <= 1'b0;
    end else if (Start) begin
      start_cnt <= start_cnt + 1;
      held_a    <= InA;
      held_b    <= InB;
      have_held <= 1'b1;
    end else if (Busy && have_held && ((InA !== held_a) || (InB !== held_b))) begin
      viol <= viol + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction. The core raises Busy ack_dly cycles after the first
  // WAIT_ACK cycle and keeps it high for busy_len cycles; result = a + b.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input int ack_dly, input int busy_len, input int bp);
    logic [7:0] exp_data;
    logic       exp_err;
    int         lat;
    int         c;
    int         s0;
    bit         seen;
    if (ack_dly >= ACK_T) begin
      exp_err = 1'b1; exp_data = 8'h00; lat = 1 + ACK_T;
    end else if (busy_len - 1 >= DONE_T) begin
      exp_err = 1'b1; exp_data = 8'h00; lat = 2 + ack_dly + DONE_T;
    end else begin
      exp_err = 1'b0; exp_data = a + b; lat = 2 + ack_dly + busy_len;
    end
    req_a = a; req_b = b; req_valid = 1'b1;
    #1;
    chk("req_ready_idle", 32'(req_ready), 1);
    s0 = start_cnt;
    tick;
    req_valid = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c <= lat + 20) begin
      Busy = (c >= 1 + ack_dly) && (c <= ack_dly + busy_len);
      Out  = Busy ? 8'($urandom) : exp_data;
      if (c == 0) begin
        chk("start_launch", 32'(Start), 1);
        chk("ina_launch", 32'(InA), 32'(a));
        chk("inb_launch", 32'(InB), 32'(b));
      end
      if (rsp_valid) begin
        seen = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
      end else begin
        // Junk that must be ignored outside IDLE / RESP.
        rsp_ready = 1'($urandom_range(0, 1));
        req_valid = 1'($urandom_range(0, 1));
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        tick;
        c++;
      end
    end
    chk("rsp_latency", 32'(c), 32'(lat));
    chk("start_pulses", 32'(start_cnt - s0), 1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < bp; k++) begin
      tick;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'(exp_data));
      chk("bp_err", 32'(rsp_err), 32'(exp_err));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
    chk("op_count", 32'(op_count), 32'(exp_cnt % 256));
    if (Busy) begin
      chk("req_ready_busy", 32'(req_ready), 0);
      Busy = 1'b0;
      #1;
    end
    chk("req_ready_after", 32'(req_ready), 1);
  endtask

  initial begin
    req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00;
    Busy = 1'b0; Out = 8'h00; rsp_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_start", 32'(Start), 0);
    chk("rst_ina", 32'(InA), 0);
    chk("rst_inb", 32'(InB), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    repeat (2) tick;
    reset = 1'b0;
    tick;

    // Reference example, then backpressure, both timeouts and the done boundary.
    run_txn(8'h12, 8'h34, 0, 6, 0);
    run_txn(8'($urandom), 8'($urandom), 2, 3, 5);
    run_txn(8'($urandom), 8'($urandom), 1000, 1, 1);
    run_txn(8'($urandom), 8'($urandom), 3, 4, 0);
    run_txn(8'($urandom), 8'($urandom), 0, DONE_T, 0);
    run_txn(8'($urandom), 8'($urandom), 1, 2000, 2);

    // Busy already high in IDLE: requests are refused until it drops.
    Busy = 1'b1; req_valid = 1'b1; req_a = 8'h77; req_b = 8'h88;
    #1;
    chk("busy_idle_ready", 32'(req_ready), 0);
    tick;
    chk("busy_idle_nostart", 32'(Start), 0);
    tick;
    chk("busy_idle_nostart2", 32'(Start), 0);
    req_valid = 1'b0;
    Busy = 1'b0;
    #1;
    chk("busy_idle_release", 32'(req_ready), 1);

    // Reset in the middle of WAIT_DONE abandons the job.
    req_a = 8'h5A; req_b = 8'hA5; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    Busy = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_start", 32'(Start), 0);
    chk("mid_rst_ina", 32'(InA), 0);
    chk("mid_rst_inb", 32'(InB), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 0);
    chk("mid_rst_op_count", 32'(op_count), 0);
    chk("mid_rst_ready_busy", 32'(req_ready), 0);
    Busy = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 1);
    tick;
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("post_rst_no_rsp", 32'(rsp_valid), 0);
    end

    // 256 randomized back-to-back jobs wrap the counter to zero.
    for (int n = 0; n < 256; n++) begin
      run_txn(8'($urandom), 8'($urandom), $urandom_range(0, ACK_T - 1),
              $urandom_range(1, 8), $urandom_range(0, 2));
    end
    chk("op_count_wrap", 32'(op_count), 0);
    chk("operand_stability", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
